// File: rtl/debounce_gpi_core.sv
// Debounced general-purpose input block with a small MMIO register slot.
// Each input bit has its own lane: synchronizer, stability counter, edge flags.

module debounce_gpi_lane #(
  parameter int DB_TICKS = 2000000,
  parameter int CW       = $clog2(DB_TICKS)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_din,
  input  logic i_rise_clr,
  input  logic i_fall_clr,
  output logic o_sync2,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);
  logic          r_sync1, r_sync2, r_db, r_rise, r_fall;
  logic [CW-1:0] r_cnt;
  logic          w_diff, w_hit;

  assign w_diff = (r_sync2 != r_db);
  assign w_hit  = w_diff && (r_cnt == CW'(DB_TICKS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      // Any cycle without a mismatch restarts the count, so glitches never accumulate.
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_hit) begin
        r_cnt <= '0;
        r_db  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // A new edge beats a W1C clear landing on the same cycle.
      r_rise <= (r_rise & ~i_rise_clr) | (w_hit &  r_sync2);
      r_fall <= (r_fall & ~i_fall_clr) | (w_hit & ~r_sync2);
    end
  end

  assign o_sync2 = r_sync2;
  assign o_db    = r_db;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
endmodule

module debounce_gpi_core #(
  parameter int W        = 8,
  parameter int DB_TICKS = 2000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  output logic [31:0]  rd_data,
  input  logic [31:0]  wr_data,
  input  logic [W-1:0] din,
  output logic         irq
);
  localparam int CW = $clog2(DB_TICKS);

  logic [W-1:0] w_sync2, w_db, w_rise, w_fall;
  logic [W-1:0] w_rise_clr, w_fall_clr;
  logic [W-1:0] r_mask;
  logic         w_wr;
  logic         w_unused;

  assign w_wr       = cs & write;
  assign w_rise_clr = (w_wr && addr == 5'd1) ? wr_data[W-1:0] : '0;
  assign w_fall_clr = (w_wr && addr == 5'd2) ? wr_data[W-1:0] : '0;
  // Reads have no side effects; the strobe is accepted but not used.
  assign w_unused   = ^{read, wr_data};

  debounce_gpi_lane #(.DB_TICKS(DB_TICKS), .CW(CW)) u_lane [W-1:0] (
    .clk        (clk),
    .reset      (reset),
    .i_din      (din),
    .i_rise_clr (w_rise_clr),
    .i_fall_clr (w_fall_clr),
    .o_sync2    (w_sync2),
    .o_db       (w_db),
    .o_rise     (w_rise),
    .o_fall     (w_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_mask <= '0;
    else if (w_wr && addr == 5'd3)  r_mask <= wr_data[W-1:0];
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0:    rd_data[W-1:0] = w_db;
      5'd1:    rd_data[W-1:0] = w_rise;
      5'd2:    rd_data[W-1:0] = w_fall;
      5'd3:    rd_data[W-1:0] = r_mask;
      5'd4:    rd_data[W-1:0] = w_sync2;
      default: rd_data        = '0;
    endcase
  end

  assign irq = |((w_rise | w_fall) & r_mask);
endmodule

// File: tb/tb_debounce_gpi_core.sv
// Directed bench for debounce_gpi_core with W=4, DB_TICKS=4.
module tb_debounce_gpi_core;
  logic        clk = 1'b0;
  logic        reset;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] rd_data, wr_data;
  logic [3:0]  din;
  logic        irq;
  int          n_vec = 0;
  int          n_err = 0;

  debounce_gpi_core #(.W(4), .DB_TICKS(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .rd_data(rd_data), .wr_data(wr_data), .din(din), .irq(irq)
  );

  always #10 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    addr = a; wr_data = d; cs = 1'b1; write = 1'b1;
    step(1);
    cs = 1'b0; write = 1'b0; wr_data = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int a = 0; a < 5; a++) rd(5'(a), tag, 32'h0);
    chk({tag, "_irq"}, {31'b0, irq}, 32'h0);
  endtask

  initial begin
    reset = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0; din = '0;
    #5;
    chk_all_zero("reset_state");
    step(2);
    reset = 1'b1;

    // din[0] rises before edge k; db must move at k+5, not k+4
    din = 4'h1;
    step(5);
    rd(0, "db_k4", 32'h0);
    step(1);
    rd(0, "db_k5", 32'h1);
    rd(1, "rise_k5", 32'h1);
    chk("irq_unmasked", {31'b0, irq}, 32'h0);

    // three-cycle glitch on din[1] is visible raw but never debounced
    din = 4'h3;
    step(2);
    rd(4, "sync2_glitch", 32'h3);
    step(1);
    din = 4'h1;
    step(5);
    rd(0, "db_glitch", 32'h1);
    rd(1, "rise_glitch", 32'h1);
    rd(4, "sync2_after", 32'h1);
    chk("irq_glitch", {31'b0, irq}, 32'h0);

    wr(1, 32'h1);
    rd(1, "rise_w1c", 32'h0);

    // W1C of rise[3] on the very edge it gets set: set wins
    din = 4'h9;
    step(5);
    rd(0, "db3_k4", 32'h1);
    wr(1, 32'h8);
    rd(0, "db3_k5", 32'h9);
    rd(1, "rise_set_wins", 32'h8);

    wr(3, 32'hF);
    rd(3, "mask_rd", 32'hF);
    chk("irq_rise", {31'b0, irq}, 32'h1);
    wr(1, 32'h8);
    chk("irq_cleared", {31'b0, irq}, 32'h0);

    // din[2] debounced high, then low -> fall[2] and irq
    din = 4'hD;
    step(6);
    rd(0, "db2_hi", 32'hD);
    rd(1, "rise2", 32'h4);
    wr(1, 32'h4);
    din = 4'h9;
    step(6);
    rd(0, "db2_lo", 32'h9);
    rd(2, "fall2", 32'h4);
    chk("irq_fall", {31'b0, irq}, 32'h1);

    // no-effect accesses: cs=0 writes, read strobe, unmapped address
    addr = 5'd2; wr_data = 32'h4; write = 1'b1; cs = 1'b0;
    step(1);
    addr = 5'd3; wr_data = 32'h0;
    step(1);
    write = 1'b0; read = 1'b1; cs = 1'b1; addr = 5'd2;
    step(1);
    read = 1'b0; cs = 1'b0;
    rd(2, "fall_cs0", 32'h4);
    rd(3, "mask_cs0", 32'hF);
    wr(7, 32'hFFFF_FFFF);
    rd(1, "rise_a7", 32'h0);
    rd(2, "fall_a7", 32'h4);
    rd(3, "mask_a7", 32'hF);
    rd(5, "addr5", 32'h0);
    rd(7, "addr7", 32'h0);
    rd(31, "addr31", 32'h0);

    wr(3, 32'h0);
    chk("irq_masked", {31'b0, irq}, 32'h0);
    wr(3, 32'hF);
    chk("irq_unmask", {31'b0, irq}, 32'h1);
    wr(2, 32'h4);
    rd(2, "fall_w1c", 32'h0);
    chk("irq_fall_w1c", {31'b0, irq}, 32'h0);

    // din=0xF held through reset release
    din = 4'hF;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset1");
    step(1);
    reset = 1'b1;
    step(5);
    rd(0, "rel_db_early", 32'h0);
    step(1);
    rd(0, "rel_db", 32'hF);
    rd(1, "rel_rise", 32'hF);
    wr(3, 32'hF);
    chk("rel_irq", {31'b0, irq}, 32'h1);

    // reset mid-count, no clock edge needed to clear
    din = 4'h0;
    step(4);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset2");
    din = 4'h1;
    step(1);
    reset = 1'b1;
    step(5);
    rd(0, "recount_early", 32'h0);
    step(1);
    rd(0, "recount_db", 32'h1);
    rd(1, "recount_rise", 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
